vx_mem_stage_ctrl: RTL and testbench
====================================

# vx_mem_stage_ctrl

Parametrised memory-stage controller between execute and writeback. It registers one warp instruction, issues a valid/ready request to the cache driver for loads and stores, waits for load data, and resolves branches per thread. It presents a registered result to writeback under valid/ready backpressure. It replaces the purely combinational pass-through stage: it adds real stall generation (`out_delay`), a per-thread taken mask and a divergence flag.

## Interface
- `NT`, 4, threads per warp (≥1)
- `NW`, 8, warps; `NW_W = max(1,$clog2(NW))`
- `DW`, 32, lane data width (addresses and PC stay 32 bits)

- `clk` in 1 — clock
- `reset` in 1 — asynchronous, active-high
- `in_valid` in 1 — instruction offered by execute
- `in_ready` out 1 — stage accepts this cycle
- `in_thread_mask` in NT — active threads
- `in_alu_result` in NT*DW — per-lane ALU result / address, lane i at [i*DW+:DW]
- `in_rd2` in NT*DW — store data
- `in_mem_read`, `in_mem_write` in 3 each — 3'd7 = none
- `in_rd` in 5, `in_wb` in 2, `in_warp_num` in NW_W
- `in_PC_next`, `in_curr_PC`, `in_branch_offset` in 32 each
- `in_branch_type` in 3 — 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGT, 5 BLTU, 6 BGTU, 7 treated as none
- `creq_valid` out 1, `creq_ready` in 1 — cache request handshake
- `creq_addr`, `creq_data` out NT*DW; `creq_mask` out NT; `creq_mem_read`, `creq_mem_write` out 3
- `crsp_valid` in 1, `crsp_data` in NT*DW — load response
- `out_valid` out 1, `out_ready` in 1 — writeback handshake
- `out_thread_mask` out NT; `out_alu_result`, `out_mem_result` out NT*DW; `out_rd` out 5; `out_wb` out 2; `out_warp_num` out NW_W; `out_PC_next` out 32
- `out_branch_dir` out 1, `out_branch_dest` out 32, `out_branch_taken_mask` out NT, `out_branch_divergent` out 1
- `out_delay` out 1 — equals `!in_ready`

## Operation
- States: IDLE, REQ, WAIT, DONE. All instruction fields are captured into an internal register on accept (`in_valid && in_ready`).
- `in_ready` = (state==IDLE) || (state==DONE && `out_ready`).
- An instruction is a mem op iff (read≠7 or write≠7) and mask≠0. Accept of a mem op goes to REQ; accept of any other instruction goes to DONE.
- REQ: `creq_valid`=1; the `creq_*` fields come from the captured register and hold stable until `creq_ready`. On the handshake, a read goes to WAIT; a write-only op goes to DONE. `out_mem_result` for a write-only op is 0.
- WAIT: on `crsp_valid`, capture `crsp_data` into `out_mem_result` and go to DONE. `crsp_valid` is ignored in all other states.
- DONE: `out_valid`=1 and all `out_*` hold stable until `out_ready`. On `out_ready`, go to IDLE, or reload per the accept rule if `in_valid` is high in the same cycle (back-to-back).
- Branch, computed on accept and registered. Each lane i is evaluated only when `mask[i]`=1. With r = lane result:
  - BEQ: taken when r==0
  - BNE: taken when r≠0
  - BLT and BLTU: taken when r[DW-1]=1
  - BGT and BGTU: taken when r[DW-1]=0
  - Lanes with mask 0 report 0.
- `out_branch_dir` = taken bit of the lowest-index active lane. It is 0 for no branch or an empty mask.
- `out_branch_divergent` = (taken_mask≠0) && (taken_mask≠mask).
- `out_branch_dest` = `in_curr_PC` + (`in_branch_offset`<<1), modulo 2^32 (wraps, no overflow flag).
- Branch and mem are independent; an instruction carrying both completes both.

## Timing
- Reset (asynchronous): state IDLE, every output register 0, `creq_valid`=0, `out_valid`=0, `in_ready`=1. Reset during REQ or WAIT abandons the op; a late `crsp_valid` after reset is ignored.
- Non-mem latency: `out_valid` is high in the cycle after accept.
- Store: `creq_valid` rises in the cycle after accept; DONE follows the handshake cycle.
- Load: `out_valid` rises in the cycle after `crsp_valid`.
- `crsp_valid` in the same cycle as the request handshake is not allowed; the cache responds no earlier than the next cycle.
- Throughput: one non-mem instruction per cycle while `out_ready`=1.

## Test plan
- ALU op, mask 4'b1111, `out_ready`=1, back-to-back for 4 cycles → 4 consecutive `out_valid` cycles, `in_ready` stays 1, `creq_valid` never asserts.
- LW, read=2, lanes 0x100/0x104/0x108/0x10C, `creq_ready` low 3 cycles then high, `crsp_valid` 2 cycles later with 0xA..D → `creq` fields stable while stalled, `out_mem_result` = A,B,C,D, `out_delay`=1 from accept until `out_valid`.
- SW, write=2, mask 4'b0101 → `creq_mask`=0101, `creq_data`=`in_rd2`, no WAIT, `out_valid` in the cycle after the handshake.
- BNE with results {0,5,0,7}, mask 1111, curr_PC 0x8000_0000, offset 0x10 → taken_mask 1010, dir 0 (lane 0), divergent 1, dest 0x8000_0020. Same with PC 0xFFFF_FFF0, offset 0x10 → dest 0x0000_0010.
- `out_ready` held low 5 cycles in DONE → `out_*` constant, `in_ready`=0. Release with `in_valid` high → new instruction accepted in the same cycle.
- Assert `reset` during WAIT, then pulse `crsp_valid` → all outputs 0, state IDLE, no spurious `out_valid`.

Source files
------------

// File: rtl/vx_mem_stage_ctrl.sv
// Memory stage: registers one warp instruction, drives the cache request,
// waits for load data and resolves per-thread branch outcomes.
module vx_mem_stage_ctrl #(
   parameter int NT   = 4,
   parameter int NW   = 8,
   parameter int DW   = 32,
   parameter int NW_W = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NT-1:0]      in_thread_mask,
   input  logic [NT*DW-1:0]   in_alu_result,
   input  logic [NT*DW-1:0]   in_rd2,
   input  logic [2:0]         in_mem_read,
   input  logic [2:0]         in_mem_write,
   input  logic [4:0]         in_rd,
   input  logic [1:0]         in_wb,
   input  logic [NW_W-1:0]    in_warp_num,
   input  logic [31:0]        in_PC_next,
   input  logic [31:0]        in_curr_PC,
   input  logic [31:0]        in_branch_offset,
   input  logic [2:0]         in_branch_type,
   output logic               creq_valid,
   input  logic               creq_ready,
   output logic [NT*DW-1:0]   creq_addr,
   output logic [NT*DW-1:0]   creq_data,
   output logic [NT-1:0]      creq_mask,
   output logic [2:0]         creq_mem_read,
   output logic [2:0]         creq_mem_write,
   input  logic               crsp_valid,
   input  logic [NT*DW-1:0]   crsp_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NT-1:0]      out_thread_mask,
   output logic [NT*DW-1:0]   out_alu_result,
   output logic [NT*DW-1:0]   out_mem_result,
   output logic [4:0]         out_rd,
   output logic [1:0]         out_wb,
   output logic [NW_W-1:0]    out_warp_num,
   output logic [31:0]        out_PC_next,
   output logic               out_branch_dir,
   output logic [31:0]        out_branch_dest,
   output logic [NT-1:0]      out_branch_taken_mask,
   output logic               out_branch_divergent,
   output logic               out_delay
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t              r_state, w_nstate;
   logic [NT-1:0]       r_mask, r_taken;
   logic [NT*DW-1:0]    r_alu, r_rd2, r_mem;
   logic [2:0]          r_mread, r_mwrite;
   logic [4:0]          r_rd;
   logic [1:0]          r_wb;
   logic [NW_W-1:0]     r_warp;
   logic [31:0]         r_pcn, r_dest;
   logic                r_dir, r_div;

   logic                w_acc, w_is_mem, w_dir;
   logic [NT-1:0]       w_taken;

   assign w_is_mem = ((in_mem_read != 3'd7) || (in_mem_write != 3'd7))
                     && (|in_thread_mask);
   assign w_acc    = in_valid && in_ready;

   always_comb begin
      w_nstate   = r_state;
      in_ready   = 1'b0;
      creq_valid = 1'b0;
      out_valid  = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_nstate = w_is_mem ? REQ : DONE;
         end
         REQ: begin
            creq_valid = 1'b1;
            if (creq_ready) w_nstate = (r_mread != 3'd7) ? WAIT : DONE;
         end
         WAIT: begin
            if (crsp_valid) w_nstate = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               in_ready = 1'b1;
               if (in_valid) w_nstate = w_is_mem ? REQ : DONE;
               else          w_nstate = IDLE;
            end
         end
         default: w_nstate = IDLE;
      endcase
   end

   // Only active lanes are evaluated; dir follows the lowest active lane.
   always_comb begin
      w_taken = '0;
      w_dir   = 1'b0;
      for (int i = 0; i < NT; i++) begin
         if (in_thread_mask[i]) begin
            case (in_branch_type)
               3'd1:       w_taken[i] = (in_alu_result[i*DW +: DW] == '0);
               3'd2:       w_taken[i] = (in_alu_result[i*DW +: DW] != '0);
               3'd3, 3'd5: w_taken[i] = in_alu_result[i*DW + DW - 1];
               3'd4, 3'd6: w_taken[i] = !in_alu_result[i*DW + DW - 1];
               default:    w_taken[i] = 1'b0;
            endcase
         end
      end
      for (int i = NT - 1; i >= 0; i--) begin
         if (in_thread_mask[i]) w_dir = w_taken[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nstate;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mask   <= '0;
         r_taken  <= '0;
         r_alu    <= '0;
         r_rd2    <= '0;
         r_mem    <= '0;
         r_mread  <= '0;
         r_mwrite <= '0;
         r_rd     <= '0;
         r_wb     <= '0;
         r_warp   <= '0;
         r_pcn    <= '0;
         r_dest   <= '0;
         r_dir    <= 1'b0;
         r_div    <= 1'b0;
      end else if (w_acc) begin
         r_mask   <= in_thread_mask;
         r_taken  <= w_taken;
         r_alu    <= in_alu_result;
         r_rd2    <= in_rd2;
         r_mem    <= '0;
         r_mread  <= in_mem_read;
         r_mwrite <= in_mem_write;
         r_rd     <= in_rd;
         r_wb     <= in_wb;
         r_warp   <= in_warp_num;
         r_pcn    <= in_PC_next;
         r_dest   <= in_curr_PC + (in_branch_offset << 1);
         r_dir    <= w_dir;
         r_div    <= (w_taken != '0) && (w_taken != in_thread_mask);
      end else if (r_state == WAIT && crsp_valid) begin
         r_mem    <= crsp_data;
      end
   end

   assign creq_addr             = r_alu;
   assign creq_data             = r_rd2;
   assign creq_mask             = r_mask;
   assign creq_mem_read         = r_mread;
   assign creq_mem_write        = r_mwrite;
   assign out_thread_mask       = r_mask;
   assign out_alu_result        = r_alu;
   assign out_mem_result        = r_mem;
   assign out_rd                = r_rd;
   assign out_wb                = r_wb;
   assign out_warp_num          = r_warp;
   assign out_PC_next           = r_pcn;
   assign out_branch_dir        = r_dir;
   assign out_branch_dest       = r_dest;
   assign out_branch_taken_mask = r_taken;
   assign out_branch_divergent  = r_div;
   assign out_delay             = !in_ready;

endmodule

// File: tb/tb_vx_mem_stage_ctrl.sv
// Directed bench for vx_mem_stage_ctrl: ALU stream, load, store,
// branch resolution, writeback backpressure and reset abandon.
module tb_vx_mem_stage_ctrl;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready;
   logic [3:0]    in_thread_mask;
   logic [127:0]  in_alu_result, in_rd2;
   logic [2:0]    in_mem_read, in_mem_write;
   logic [4:0]    in_rd;
   logic [1:0]    in_wb;
   logic [2:0]    in_warp_num;
   logic [31:0]   in_PC_next, in_curr_PC, in_branch_offset;
   logic [2:0]    in_branch_type;
   logic          creq_valid, creq_ready;
   logic [127:0]  creq_addr, creq_data;
   logic [3:0]    creq_mask;
   logic [2:0]    creq_mem_read, creq_mem_write;
   logic          crsp_valid;
   logic [127:0]  crsp_data;
   logic          out_valid, out_ready;
   logic [3:0]    out_thread_mask;
   logic [127:0]  out_alu_result, out_mem_result;
   logic [4:0]    out_rd;
   logic [1:0]    out_wb;
   logic [2:0]    out_warp_num;
   logic [31:0]   out_PC_next;
   logic          out_branch_dir;
   logic [31:0]   out_branch_dest;
   logic [3:0]    out_branch_taken_mask;
   logic          out_branch_divergent;
   logic          out_delay;

   int n_chk = 0;
   int n_pass = 0;

   vx_mem_stage_ctrl #(.NT(4), .NW(8), .DW(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_thread_mask(in_thread_mask), .in_alu_result(in_alu_result),
      .in_rd2(in_rd2), .in_mem_read(in_mem_read),
      .in_mem_write(in_mem_write), .in_rd(in_rd), .in_wb(in_wb),
      .in_warp_num(in_warp_num), .in_PC_next(in_PC_next),
      .in_curr_PC(in_curr_PC), .in_branch_offset(in_branch_offset),
      .in_branch_type(in_branch_type),
      .creq_valid(creq_valid), .creq_ready(creq_ready),
      .creq_addr(creq_addr), .creq_data(creq_data),
      .creq_mask(creq_mask), .creq_mem_read(creq_mem_read),
      .creq_mem_write(creq_mem_write),
      .crsp_valid(crsp_valid), .crsp_data(crsp_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_thread_mask(out_thread_mask), .out_alu_result(out_alu_result),
      .out_mem_result(out_mem_result), .out_rd(out_rd), .out_wb(out_wb),
      .out_warp_num(out_warp_num), .out_PC_next(out_PC_next),
      .out_branch_dir(out_branch_dir), .out_branch_dest(out_branch_dest),
      .out_branch_taken_mask(out_branch_taken_mask),
      .out_branch_divergent(out_branch_divergent),
      .out_delay(out_delay)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [2:0] rd_op, input logic [2:0] wr_op,
                        input logic [3:0] mask, input logic [127:0] alu,
                        input logic [127:0] rd2, input logic [2:0] br,
                        input logic [31:0] pc, input logic [31:0] off,
                        input logic [4:0] rd);
      in_valid         = 1'b1;
      in_mem_read      = rd_op;
      in_mem_write     = wr_op;
      in_thread_mask   = mask;
      in_alu_result    = alu;
      in_rd2           = rd2;
      in_branch_type   = br;
      in_curr_PC       = pc;
      in_branch_offset = off;
      in_rd            = rd;
      in_wb            = 2'd1;
      in_warp_num      = 3'd5;
      in_PC_next       = pc + 32'd4;
   endtask

   logic [31:0]  hold_dest;
   logic [127:0] hold_alu;

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_thread_mask = '0; in_alu_result = '0;
      in_rd2 = '0; in_mem_read = 3'd7; in_mem_write = 3'd7;
      in_rd = '0; in_wb = '0; in_warp_num = '0; in_PC_next = '0;
      in_curr_PC = '0; in_branch_offset = '0; in_branch_type = '0;
      creq_ready = 1'b0; crsp_valid = 1'b0; crsp_data = '0;
      out_ready = 1'b0;
      #3;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_creq_valid", creq_valid, 0);
      chk("rst_dest", out_branch_dest, 0);
      chk("rst_delay", out_delay, 0);
      tick();
      reset = 1'b0;

      // ALU stream, four back-to-back instructions
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         offer(3'd7, 3'd7, 4'hF, {4{32'(k + 1)}}, '0, 3'd0,
               32'h100, 32'h0, 5'(k + 1));
         #1;
         chk("alu_in_ready", in_ready, 1);
         chk("alu_creq", creq_valid, 0);
         if (k > 0) begin
            chk("alu_out_valid", out_valid, 1);
            chk("alu_out_rd", out_rd, 5'(k));
         end
         tick();
      end
      in_valid = 1'b0;
      #1;
      chk("alu_last_valid", out_valid, 1);
      chk("alu_last_rd", out_rd, 5'd4);
      chk("alu_last_res", out_alu_result, {4{32'd4}});
      tick();
      chk("alu_idle", out_valid, 0);

      // load with request stall and delayed response
      out_ready = 1'b0;
      offer(3'd2, 3'd7, 4'hF,
            {32'h10C, 32'h108, 32'h104, 32'h100}, '0, 3'd0,
            32'h200, 32'h0, 5'd9);
      #1;
      chk("lw_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("lw_creq_valid", creq_valid, 1);
         chk("lw_creq_addr", creq_addr,
             {32'h10C, 32'h108, 32'h104, 32'h100});
         chk("lw_creq_rd", creq_mem_read, 3'd2);
         chk("lw_delay_req", out_delay, 1);
         tick();
      end
      creq_ready = 1'b1;
      #1;
      chk("lw_hs_valid", creq_valid, 1);
      tick();
      creq_ready = 1'b0;
      #1;
      chk("lw_wait_creq", creq_valid, 0);
      chk("lw_wait_out", out_valid, 0);
      chk("lw_delay_wait", out_delay, 1);
      tick();
      crsp_valid = 1'b1;
      crsp_data = {32'hD, 32'hC, 32'hB, 32'hA};
      #1;
      chk("lw_rsp_out", out_valid, 0);
      tick();
      crsp_valid = 1'b0;
      crsp_data = '0;
      #1;
      chk("lw_done_valid", out_valid, 1);
      chk("lw_mem_result", out_mem_result,
          {32'hD, 32'hC, 32'hB, 32'hA});
      chk("lw_delay_done", out_delay, 1);
      out_ready = 1'b1;
      #1;
      chk("lw_delay_rel", out_delay, 0);
      tick();

      // store, write-only, partial mask
      offer(3'd7, 3'd2, 4'b0101, {32'h4C, 32'h48, 32'h44, 32'h40},
            {32'hDD, 32'hCC, 32'hBB, 32'hAA}, 3'd0, 32'h300, 32'h0, 5'd0);
      tick();
      in_valid = 1'b0;
      creq_ready = 1'b1;
      #1;
      chk("sw_creq_valid", creq_valid, 1);
      chk("sw_creq_mask", creq_mask, 4'b0101);
      chk("sw_creq_data", creq_data, {32'hDD, 32'hCC, 32'hBB, 32'hAA});
      chk("sw_creq_wr", creq_mem_write, 3'd2);
      tick();
      creq_ready = 1'b0;
      #1;
      chk("sw_out_valid", out_valid, 1);
      chk("sw_mem_zero", out_mem_result, 0);
      tick();

      // BNE, then writeback stall
      out_ready = 1'b0;
      offer(3'd7, 3'd7, 4'hF, {32'd7, 32'd0, 32'd5, 32'd0}, '0, 3'd2,
            32'h8000_0000, 32'h10, 5'd3);
      tick();
      in_valid = 1'b0;
      #1;
      chk("bne_taken", out_branch_taken_mask, 4'b1010);
      chk("bne_dir", out_branch_dir, 0);
      chk("bne_div", out_branch_divergent, 1);
      chk("bne_dest", out_branch_dest, 32'h8000_0020);
      hold_dest = 32'h8000_0020;
      hold_alu  = {32'd7, 32'd0, 32'd5, 32'd0};
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("stall_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_dest", out_branch_dest, hold_dest);
         chk("stall_alu", out_alu_result, hold_alu);
      end
      offer(3'd7, 3'd7, 4'hF, {32'd7, 32'd0, 32'd5, 32'd0}, '0, 3'd2,
            32'hFFFF_FFF0, 32'h10, 5'd4);
      out_ready = 1'b1;
      #1;
      chk("b2b_in_ready", in_ready, 1);
      tick();
      // BLT, mask 0011, lane0 negative
      offer(3'd7, 3'd7, 4'b0011, {32'h8, 32'h8, 32'h1, 32'h8000_0000},
            '0, 3'd3, 32'h0, 32'h0, 5'd5);
      #1;
      chk("wrap_dest", out_branch_dest, 32'h0000_0010);
      chk("wrap_rd", out_rd, 5'd4);
      tick();
      // BLTU, all lanes negative
      offer(3'd7, 3'd7, 4'hF, {4{32'hF000_0000}}, '0, 3'd5,
            32'h0, 32'h0, 5'd6);
      #1;
      chk("blt_taken", out_branch_taken_mask, 4'b0001);
      chk("blt_dir", out_branch_dir, 1);
      chk("blt_div", out_branch_divergent, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("bltu_taken", out_branch_taken_mask, 4'b1111);
      chk("bltu_dir", out_branch_dir, 1);
      chk("bltu_div", out_branch_divergent, 0);
      tick();

      // reset while waiting on a load response
      offer(3'd2, 3'd7, 4'hF, {4{32'h500}}, '0, 3'd0,
            32'h0, 32'h0, 5'd7);
      tick();
      in_valid = 1'b0;
      creq_ready = 1'b1;
      tick();
      creq_ready = 1'b0;
      #1;
      chk("rw_in_wait", out_delay, 1);
      reset = 1'b1;
      #1;
      chk("rw_in_ready", in_ready, 1);
      chk("rw_creq", creq_valid, 0);
      chk("rw_out_valid", out_valid, 0);
      chk("rw_rd", out_rd, 0);
      chk("rw_alu", out_alu_result, 0);
      tick();
      reset = 1'b0;
      crsp_valid = 1'b1;
      crsp_data = {4{32'hBAD}};
      tick();
      crsp_valid = 1'b0;
      #1;
      chk("rw_late_valid", out_valid, 0);
      chk("rw_late_mem", out_mem_result, 0);
      chk("rw_late_ready", in_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
